// File: rtl/fifo_drain_serial_tx.sv
// -----------------------------------------------------------------------------
// fifo_drain_serial_tx
//
// Read-side consumer for the synchronous FIFO. Pops one word at a time using
// the FIFO's registered-read protocol (one-cycle pop strobe, data valid on the
// following cycle) and sends each word as an asynchronous serial frame:
// start bit (0), WIDTH data bits LSB first, optional even-parity bit, stop
// bit (1). Every bit lasts CLKS_PER_BIT clk cycles.
//
// Build option:
//   FIFO_TX_PARITY_EN  when defined, a parity bit (XOR of the data bits) is
//                      sent between the last data bit and the stop bit.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous, active-high reset
//   i_enable       allow new words to be fetched (sampled only in IDLE)
//   i_fifo_empty   FIFO empty flag, 1 = no word available
//   i_fifo_data    FIFO registered read data
//   o_fifo_read    one-cycle pop strobe to the FIFO
//   o_tx           serial line, idle high
//   o_busy         high whenever the FSM is not in IDLE
//   o_frames_sent  count of completed frames, wraps 255 -> 0
//
// State   | meaning
// --------+-------------------------------------------------------------
// IDLE    | line high, waiting for enable and a non-empty FIFO
// FETCH   | pop strobe is on the FIFO this cycle
// LATCH   | FIFO read data valid; capture it and drop the line
// START   | start bit (0)
// DATA    | data bits, LSB first
// PARITY  | even parity bit (only with FIFO_TX_PARITY_EN)
// STOP    | stop bit (1); frame counted on its last cycle
// -----------------------------------------------------------------------------
module fifo_drain_serial_tx #(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic             i_fifo_empty,
    input  logic [WIDTH-1:0] i_fifo_data,
    output logic             o_fifo_read,
    output logic             o_tx,
    output logic             o_busy,
    output logic [7:0]       o_frames_sent
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LATCH  = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
`ifdef FIFO_TX_PARITY_EN
        S_PARITY = 3'd5,
`endif
        S_STOP   = 3'd6
    } state_t;

    state_t           r_state, w_state;
    logic [WIDTH-1:0] r_shift, w_shift;
    logic [CNT_W-1:0] r_cnt,   w_cnt;
    logic [IDX_W-1:0] r_idx,   w_idx;
    logic             r_tx,    w_tx;
    logic             r_read,  w_read;
    logic             r_busy,  w_busy;
    logic [7:0]       r_frames, w_frames;
`ifdef FIFO_TX_PARITY_EN
    logic             r_parity, w_parity;
`endif

    logic w_bit_end;
    assign w_bit_end = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_tx     <= 1'b1;
            r_read   <= 1'b0;
            r_busy   <= 1'b0;
            r_frames <= '0;
`ifdef FIFO_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state  <= w_state;
            r_shift  <= w_shift;
            r_cnt    <= w_cnt;
            r_idx    <= w_idx;
            r_tx     <= w_tx;
            r_read   <= w_read;
            r_busy   <= w_busy;
            r_frames <= w_frames;
`ifdef FIFO_TX_PARITY_EN
            r_parity <= w_parity;
`endif
        end
    end

    always_comb begin
        w_state  = r_state;
        w_shift  = r_shift;
        w_cnt    = r_cnt;
        w_idx    = r_idx;
        w_tx     = r_tx;
        w_read   = 1'b0;
        w_busy   = r_busy;
        w_frames = r_frames;
`ifdef FIFO_TX_PARITY_EN
        w_parity = r_parity;
`endif

        case (r_state)
            S_IDLE: begin
                w_tx  = 1'b1;
                w_cnt = '0;
                if (i_enable && !i_fifo_empty) begin
                    w_read  = 1'b1;
                    w_busy  = 1'b1;
                    w_state = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state = S_LATCH;
            end
            S_LATCH: begin
                // FIFO output is valid now, one cycle after the pop strobe.
                w_shift = i_fifo_data;
`ifdef FIFO_TX_PARITY_EN
                w_parity = ^i_fifo_data;
`endif
                w_tx    = 1'b0;
                w_cnt   = '0;
                w_state = S_START;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_cnt   = '0;
                    w_idx   = '0;
                    w_tx    = r_shift[0];
                    w_state = S_DATA;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt   = '0;
                    w_shift = r_shift >> 1;
                    if (r_idx == IDX_LAST) begin
`ifdef FIFO_TX_PARITY_EN
                        w_tx    = r_parity;
                        w_state = S_PARITY;
`else
                        w_tx    = 1'b1;
                        w_state = S_STOP;
`endif
                    end else begin
                        w_idx = r_idx + IDX_W'(1);
                        w_tx  = w_shift[0];
                    end
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
`ifdef FIFO_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_cnt   = '0;
                    w_tx    = 1'b1;
                    w_state = S_STOP;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    w_cnt    = '0;
                    w_frames = r_frames + 8'd1;
                    w_busy   = 1'b0;
                    w_state  = S_IDLE;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state = S_IDLE;
                w_tx    = 1'b1;
                w_busy  = 1'b0;
                w_cnt   = '0;
            end
        endcase
    end

    assign o_fifo_read   = r_read;
    assign o_tx          = r_tx;
    assign o_busy        = r_busy;
    assign o_frames_sent = r_frames;

endmodule

// File: tb/tb_fifo_drain_serial_tx.sv
// -----------------------------------------------------------------------------
// Directed bench for fifo_drain_serial_tx with WIDTH=4, CLKS_PER_BIT=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_fifo_drain_serial_tx;

    localparam int W   = 4;
    localparam int CPB = 4;
`ifdef FIFO_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB  = W + 2 + PAR;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       fifo_empty = 1'b0;
    logic [3:0] fifo_data = 4'hA;
    logic       fifo_read;
    logic       tx;
    logic       busy;
    logic [7:0] frames_sent;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    fifo_drain_serial_tx #(
        .WIDTH(W),
        .CLKS_PER_BIT(CPB),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_enable(enable),
        .i_fifo_empty(fifo_empty),
        .i_fifo_data(fifo_data),
        .o_fifo_read(fifo_read),
        .o_tx(tx),
        .o_busy(busy),
        .o_frames_sent(frames_sent)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ticks until the pop strobe is seen, at most max_cycles; returns ticks used.
    task automatic wait_read(input int max_cycles, output int n);
        n = 0;
        while (fifo_read !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
    endtask

    // Called at the sample point where fifo_read was first seen high.
    // Checks the whole frame; nd/ne are applied to the FIFO inputs once the
    // word has been latched; enable drops at the start of frame bit drop_bit.
    task automatic check_frame(input logic [3:0] d, input logic [3:0] nd,
                               input logic ne, input int drop_bit);
        logic exp_bit;
        tick();
        chk("fetch_read_low", {31'd0, fifo_read}, 32'd0);
        chk("fetch_tx_high", {31'd0, tx}, 32'd1);
        chk("fetch_busy", {31'd0, busy}, 32'd1);
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < CPB; c++) begin
                tick();
                if (b == 0 && c == 0) begin
                    fifo_data  = nd;
                    fifo_empty = ne;
                end
                if (b == drop_bit && c == 0) enable = 1'b0;
                if (b == 0)                    exp_bit = 1'b0;
                else if (b <= W)               exp_bit = d[b-1];
                else if (PAR == 1 && b == W+1) exp_bit = ^d;
                else                           exp_bit = 1'b1;
                chk($sformatf("tx_bit%0d_c%0d", b, c), {31'd0, tx}, {31'd0, exp_bit});
                chk("no_pop_in_frame", {31'd0, fifo_read}, 32'd0);
                chk("busy_in_frame", {31'd0, busy}, 32'd1);
            end
        end
    endtask

    initial begin
        int n;
        int t_first;

        // Reset held with a pending word and enable high.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_tx", {31'd0, tx}, 32'd1);
            chk("rst_read", {31'd0, fifo_read}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_frames", {24'd0, frames_sent}, 32'd0);
        end

        // Single word 1010: start 0, data 0,1,0,1, [parity 0], stop 1.
        rst = 1'b0;
        wait_read(10, n);
        chk("single_read_latency", n, 1);
        check_frame(4'hA, 4'hA, 1'b1, -1);
        tick();
        chk("single_busy_low", {31'd0, busy}, 32'd0);
        chk("single_frames", {24'd0, frames_sent}, 32'd1);
        chk("single_tx_idle", {31'd0, tx}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("single_one_pop", {31'd0, fifo_read}, 32'd0);
        end

        // Two words 3 then C, back to back, from a fresh reset.
        rst = 1'b1;
        tick();
        tick();
        chk("rst2_frames", {24'd0, frames_sent}, 32'd0);
        rst = 1'b0;
        fifo_data  = 4'h3;
        fifo_empty = 1'b0;
        wait_read(10, n);
        chk("b2b_first_read", n, 1);
        t_first = cyc;
        check_frame(4'h3, 4'hC, 1'b0, -1);
        wait_read(10, n);
        chk("b2b_second_read_found", n, 2);
        chk("b2b_read_spacing", cyc - t_first, NB * CPB + 3);
        check_frame(4'hC, 4'hC, 1'b1, -1);
        tick();
        chk("b2b_busy_low", {31'd0, busy}, 32'd0);
        chk("b2b_frames", {24'd0, frames_sent}, 32'd2);

        // Empty FIFO with enable high: nothing happens.
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("empty_no_read", {31'd0, fifo_read}, 32'd0);
            chk("empty_tx", {31'd0, tx}, 32'd1);
            chk("empty_busy", {31'd0, busy}, 32'd0);
        end

        // enable dropped during data bit 1 of word 5: frame still completes.
        fifo_data  = 4'h5;
        fifo_empty = 1'b0;
        wait_read(10, n);
        chk("dropen_read", n, 1);
        check_frame(4'h5, 4'h5, 1'b0, 2);
        tick();
        chk("dropen_frames", {24'd0, frames_sent}, 32'd3);
        chk("dropen_busy_low", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("dropen_no_fetch", {31'd0, fifo_read}, 32'd0);
            chk("dropen_idle_busy", {31'd0, busy}, 32'd0);
        end

        // Reset during data bit 2 of word B (bit 2 = 0, so tx is low there).
        enable    = 1'b1;
        fifo_data = 4'hB;
        wait_read(10, n);
        chk("abort_read", n, 1);
        for (int i = 0; i < 2 + 3 * CPB; i++) tick();
        chk("abort_pre_tx", {31'd0, tx}, 32'd0);
        chk("abort_pre_frames", {24'd0, frames_sent}, 32'd3);
        rst = 1'b1;
        #1;
        chk("abort_tx", {31'd0, tx}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_read_low", {31'd0, fifo_read}, 32'd0);
        chk("abort_frames", {24'd0, frames_sent}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        wait_read(10, n);
        chk("restart_read_latency", n, 1);
        check_frame(4'hB, 4'hB, 1'b1, -1);
        tick();
        chk("restart_frames", {24'd0, frames_sent}, 32'd1);
        chk("restart_busy_low", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_drain_serial_tx.md
Name:
fifo_drain_serial_tx

Overview:
- Read-side consumer for the team's synchronous FIFO.
- Pops one word at a time using the FIFO's registered-read protocol: assert read for one cycle, data is valid on the FIFO's data output the following cycle.
- Transmits each popped word as an asynchronous serial frame: start bit, data LSB first, stop bit.
- Sits between the FIFO read port and an off-block serial line.

Parameters:
- WIDTH, 4, data word width; must match the FIFO width.
- CLKS_PER_BIT, 16, clk cycles per serial bit; minimum 2.
- CNT_W, 8, width of the bit-period counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- enable  input  1  allow new words to be fetched; sampled only in IDLE.
- fifo_empty  input  1  FIFO empty flag; 1 = no word available.
- fifo_data  input  WIDTH  FIFO registered read data.
- fifo_read  output  1  one-cycle pop strobe to the FIFO.
- tx  output  1  serial line; idle high.
- busy  output  1  high whenever the state is not IDLE.
- frames_sent  output  8  count of completed frames; wraps 255 -> 0.

Behaviour:
- All outputs registered.
- Reset values: tx=1, fifo_read=0, busy=0, frames_sent=0, state=IDLE, shift register=0, bit counter=0.
- States: IDLE, FETCH, LATCH, START, DATA, [PARITY], STOP.
- IDLE:
  - If enable=1 and fifo_empty=0 at an edge: fifo_read<=1, busy<=1, go to FETCH.
  - Otherwise stay in IDLE with tx=1.
- FETCH: fifo_read<=0; go to LATCH. Exactly one fifo_read pulse per frame.
- LATCH: shift register<=fifo_data; tx<=0; go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx=shift[0] for CLKS_PER_BIT cycles, then shift right.
  - After WIDTH bits, go to PARITY if enabled, otherwise to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - On the last cycle: frames_sent+=1, go to IDLE, busy<=0.
- Latency: tx falls 3 rising edges after the IDLE edge that saw enable=1 and fifo_empty=0.
- Frame length, start-bit fall to end of stop bit: (WIDTH+2)*CLKS_PER_BIT cycles.
- Back-to-back: from IDLE on the cycle after STOP ends, the next fetch starts immediately if enable=1 and fifo_empty=0. Minimum gap between frames is 3 cycles of tx=1 beyond the stop bit.
- enable deasserted mid-frame: the current frame completes; no further fetch.
- fifo_empty changing after FETCH: ignored; the popped word is always sent.
- Never pops while not in IDLE.
- Never pops when fifo_empty=1, including on the cycle the flag rises.
- rst mid-frame: immediate abort; tx=1, fifo_read=0, busy=0; frames_sent cleared. A partial frame is not counted.
- Bit counter counts 0..CLKS_PER_BIT-1 and resets on every bit transition.

Optional Feature:
- Macro: FIFO_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - tx = even parity (XOR of all WIDTH data bits) for CLKS_PER_BIT cycles.
  - Frame length becomes (WIDTH+3)*CLKS_PER_BIT.
- Undefined: no PARITY state; DATA goes directly to STOP; frame length as above.

Test Plan:
- Reset: hold rst with fifo_empty=0 and enable=1 -> tx=1, fifo_read=0, busy=0, frames_sent=0 throughout.
- Single word (WIDTH=4, CLKS_PER_BIT=4), fifo_data=4'b1010:
  - Exactly one fifo_read pulse.
  - tx low 3 edges later, then 4-cycle bits 0,0,1,0,1,1.
  - With the macro, parity bit 0 precedes stop.
  - frames_sent=1; busy low after stop.
- Two words 4'h3, 4'hC queued:
  - Two fifo_read pulses, separated by exactly (WIDTH+2)*4+3 cycles (+4 with parity).
  - Data bits 1,1,0,0 then 0,0,1,1; frames_sent=2.
- Empty FIFO with enable=1 for 100 cycles -> no fifo_read, tx=1, busy=0.
- enable dropped during DATA of word 4'h5 -> frame completes (bits 1,0,1,0), then no further fetch although fifo_empty=0.
- rst asserted during DATA bit 2 -> tx=1 in the same cycle, frames_sent=0. After release with enable=1 and fifo_empty=0, a fresh frame starts 3 edges after the first IDLE sample.
